// File: rtl/fifo_bus_arbiter_pkg.sv
// Shared types and constants for the FT245-style FIFO bus arbiter.
// Includes the round-robin pick used when the bus is idle.
package fifo_bus_arbiter_pkg;

    localparam int unsigned DataWidth = 7;
    localparam int unsigned CntWidth  = 8;
    localparam int unsigned NumReq    = 3;

    localparam int unsigned DefSetupCycles   = 1;
    localparam int unsigned DefStrobeCycles  = 2;
    localparam int unsigned DefRecoverCycles = 3;

    // Requester indices; also the encoding of the round-robin pointer
    localparam logic [1:0] ReqRd = 2'd0;
    localparam logic [1:0] ReqW0 = 2'd1;
    localparam logic [1:0] ReqW1 = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRdStrobe,
        StWrSetup,
        StWrStrobe,
        StWrHold,
        StRecover
    } state_e;

    // One-hot grant: first pending requester strictly after last, circularly
    function automatic logic [2:0] rr_grant(input logic [1:0] last, input logic [2:0] pend);
        logic [2:0] gnt;
        logic [1:0] idx;
        gnt = '0;
        for (int unsigned i = 1; i <= NumReq; i++) begin
            idx = 2'((32'(last) + i) % NumReq);
            if (pend[idx] && gnt == '0) begin
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/fifo_flag_sync.sv
// Two-flop synchronizer for the asynchronous FIFO flags.
// Resets to all ones, i.e. flags inactive.
module fifo_flag_sync #(
    parameter int unsigned Width = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [Width-1:0] async_in,
    output logic [Width-1:0] sync_out
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/fifo_bus_arbiter.sv
// Round-robin sequencer for a shared FT245-style FIFO bus: one reader, two writers.
// Generates RD#/WR# with programmable setup/strobe/recovery and owns the data bus.
module fifo_bus_arbiter
    import fifo_bus_arbiter_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES   = DefSetupCycles,
    parameter int unsigned STROBE_CYCLES  = DefStrobeCycles,
    parameter int unsigned RECOVER_CYCLES = DefRecoverCycles
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    output logic                 rd_valid,
    output logic [DataWidth-1:0] rd_data,
    input  logic                 wr0_req,
    input  logic [DataWidth-1:0] wr0_data,
    output logic                 wr0_ack,
    input  logic                 wr1_req,
    input  logic [DataWidth-1:0] wr1_data,
    output logic                 wr1_ack,
    input  logic                 fifo_rxf,
    input  logic                 fifo_txe,
    output logic                 fifo_rd,
    output logic                 fifo_wr,
    inout  wire  [DataWidth-1:0] fifo_data,
    output logic                 busy
);

    localparam logic [CntWidth-1:0] SetupLoad   = CntWidth'(SETUP_CYCLES - 1);
    localparam logic [CntWidth-1:0] StrobeLoad  = CntWidth'(STROBE_CYCLES - 1);
    localparam logic [CntWidth-1:0] RecoverLoad = CntWidth'(RECOVER_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [1:0]           last_q, last_d;
    logic                 wsel_q, wsel_d;
    logic [DataWidth-1:0] wdata_q, wdata_d;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 ack0_q, ack0_d, ack1_q, ack1_d;
    logic                 fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
    logic                 drive_q, drive_d;
    logic                 busy_q, busy_d;

    logic [1:0] flags_s;
    logic       rxf_s, txe_s;
    logic [2:0] pend, grant;
    logic       cnt_zero;

    fifo_flag_sync #(
        .Width(2)
    ) u_flag_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in ({fifo_rxf, fifo_txe}),
        .sync_out (flags_s)
    );

    assign rxf_s    = flags_s[1];
    assign txe_s    = flags_s[0];
    assign pend     = {wr1_req & ~txe_s, wr0_req & ~txe_s, rd_req & ~rxf_s};
    assign grant    = rr_grant(last_q, pend);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wsel_d  = wsel_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (grant[ReqRd]) begin
                    state_d = StRdStrobe;
                    cnt_d   = StrobeLoad;
                    last_d  = ReqRd;
                end else if (grant[ReqW0]) begin
                    state_d = StWrSetup;
                    cnt_d   = SetupLoad;
                    last_d  = ReqW0;
                    wsel_d  = 1'b0;
                    wdata_d = wr0_data;
                end else if (grant[ReqW1]) begin
                    state_d = StWrSetup;
                    cnt_d   = SetupLoad;
                    last_d  = ReqW1;
                    wsel_d  = 1'b1;
                    wdata_d = wr1_data;
                end
            end
            StRdStrobe: begin
                if (cnt_zero) begin
                    state_d = StRecover;
                    cnt_d   = RecoverLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrSetup: begin
                if (cnt_zero) begin
                    state_d = StWrStrobe;
                    cnt_d   = StrobeLoad;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrStrobe: begin
                if (cnt_zero) begin
                    state_d = StWrHold;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWrHold: begin
                state_d = StRecover;
                cnt_d   = RecoverLoad;
            end
            StRecover: begin
                if (cnt_zero) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered, so decode them from the next state
    always_comb begin
        fifo_rd_d  = (state_d != StRdStrobe);
        fifo_wr_d  = (state_d != StWrStrobe);
        drive_d    = (state_d == StWrSetup) || (state_d == StWrStrobe) || (state_d == StWrHold);
        busy_d     = (state_d != StIdle);
        rd_valid_d = (state_q == StRdStrobe) && cnt_zero;
        rd_data_d  = rd_valid_d ? fifo_data : rd_data_q;
        ack0_d     = (state_q == StWrStrobe) && cnt_zero && !wsel_q;
        ack1_d     = (state_q == StWrStrobe) && cnt_zero && wsel_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= ReqW1;
            wsel_q     <= 1'b0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            fifo_rd_q  <= 1'b1;
            fifo_wr_q  <= 1'b1;
            drive_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            wsel_q     <= wsel_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            drive_q    <= drive_d;
            busy_q     <= busy_d;
        end
    end

    assign fifo_data = drive_q ? wdata_q : 'z;
    assign fifo_rd   = fifo_rd_q;
    assign fifo_wr   = fifo_wr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign wr0_ack   = ack0_q;
    assign wr1_ack   = ack1_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_bus_arbiter.sv
// Bench for fifo_bus_arbiter: transfer-level timing model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fifo_bus_arbiter;

    localparam int Su = 1;
    localparam int St = 2;
    localparam int Rc = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       rd_req, wr0_req, wr1_req;
    logic [6:0] wr0_data, wr1_data;
    logic       fifo_rxf, fifo_txe;
    logic       rd_valid, wr0_ack, wr1_ack, fifo_rd, fifo_wr, busy;
    logic [6:0] rd_data;
    logic [6:0] fifo_byte;
    wire  [6:0] fifo_data;

    always #5 clk = ~clk;

    // FIFO side drives the bus while RD# is low; idle bus floats high
    assign fifo_data = (fifo_rd == 1'b0) ? fifo_byte : 7'bz;
    for (genvar i = 0; i < 7; i++) begin : g_pull
        pullup (fifo_data[i]);
    end

    fifo_bus_arbiter #(
        .SETUP_CYCLES   (Su),
        .STROBE_CYCLES  (St),
        .RECOVER_CYCLES (Rc)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr0_req   (wr0_req),
        .wr0_data  (wr0_data),
        .wr0_ack   (wr0_ack),
        .wr1_req   (wr1_req),
        .wr1_data  (wr1_data),
        .wr1_ack   (wr1_ack),
        .fifo_rxf  (fifo_rxf),
        .fifo_txe  (fifo_txe),
        .fifo_rd   (fifo_rd),
        .fifo_wr   (fifo_wr),
        .fifo_data (fifo_data),
        .busy      (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transfer-level model: each grant at edge ge fixes the whole waveform by arithmetic
    int         n = 0, kind = 0, ge = 0, free_at = 0, last_m = 2;
    bit         model_ok = 1'b0;
    logic       rs1, rs2, ts1, ts2;
    logic [6:0] wd_m = '0, exp_rd_data = '0, exp_bus;
    logic       exp_rd, exp_wr, exp_drive, exp_valid, exp_ack0, exp_ack1, exp_busy;

    always @(posedge clk) begin : model
        int k, pick;
        logic [2:0] pend;
        n++;
        if (!reset) begin
            kind = 0; free_at = n + 1; last_m = 2; exp_rd_data = '0;
            rs1 = 1'b1; rs2 = 1'b1; ts1 = 1'b1; ts2 = 1'b1;
            model_ok = 1'b1;
        end else begin
            if (n >= free_at) begin
                pend = {wr1_req && !ts2, wr0_req && !ts2, rd_req && !rs2};
                pick = -1;
                for (int i = 1; i <= 3; i++) begin
                    if (pick < 0 && pend[(last_m + i) % 3]) pick = (last_m + i) % 3;
                end
                if (pick >= 0) begin
                    kind = pick + 1; ge = n; last_m = pick;
                    free_at = (pick == 0) ? n + St + Rc + 1 : n + Su + St + Rc + 2;
                    if (pick == 1) wd_m = wr0_data;
                    if (pick == 2) wd_m = wr1_data;
                end
            end
            rs2 = rs1; rs1 = fifo_rxf;
            ts2 = ts1; ts1 = fifo_txe;
        end
        k = n - ge;
        exp_rd    = !(kind == 1 && k < St);
        exp_valid = (kind == 1 && k == St);
        if (exp_valid) exp_rd_data = fifo_byte;
        exp_drive = (kind >= 2 && k <= Su + St);
        exp_wr    = !(kind >= 2 && k >= Su && k < Su + St);
        exp_ack0  = (kind == 2 && k == Su + St);
        exp_ack1  = (kind == 3 && k == Su + St);
        exp_busy  = (kind != 0 && n < free_at - 1);
        exp_bus   = exp_drive ? wd_m : (!exp_rd ? fifo_byte : 7'h7F);
    end

    // Compare process plus activity counters for the directed checks
    int         cyc = 0, rd_low_cnt = 0, wr_low_cnt = 0, rd_valid_cnt = 0;
    int         ack0_cnt = 0, ack1_cnt = 0;
    int         rd_fall_q[$];
    int         log_q[$];
    logic [6:0] last_rd_data = '0, last_wr_bus = '0, pre_fall_bus = '0, ack_bus = '0;
    logic [6:0] prev_bus = '0;
    logic       prev_rd = 1'b1, prev_wr = 1'b1;

    always @(negedge clk) begin
        if (model_ok) begin
            chk("fifo_rd", 32'(fifo_rd), 32'(exp_rd));
            chk("fifo_wr", 32'(fifo_wr), 32'(exp_wr));
            chk("fifo_data", 32'(fifo_data), 32'(exp_bus));
            chk("rd_valid", 32'(rd_valid), 32'(exp_valid));
            chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
            chk("wr0_ack", 32'(wr0_ack), 32'(exp_ack0));
            chk("wr1_ack", 32'(wr1_ack), 32'(exp_ack1));
            chk("busy", 32'(busy), 32'(exp_busy));
            cyc++;
            if (fifo_rd == 1'b0) rd_low_cnt++;
            if (fifo_rd == 1'b0 && prev_rd == 1'b1) rd_fall_q.push_back(cyc);
            if (fifo_wr == 1'b0) begin
                wr_low_cnt++;
                last_wr_bus = fifo_data;
                if (prev_wr == 1'b1) pre_fall_bus = prev_bus;
            end
            if (rd_valid) begin
                rd_valid_cnt++; last_rd_data = rd_data; log_q.push_back(0);
            end
            if (wr0_ack) begin
                ack0_cnt++; ack_bus = fifo_data; log_q.push_back(1);
            end
            if (wr1_ack) begin
                ack1_cnt++; ack_bus = fifo_data; log_q.push_back(2);
            end
            prev_rd  = fifo_rd;
            prev_wr  = fifo_wr;
            prev_bus = fifo_data;
        end
    end

    task automatic step(input int c);
        repeat (c) @(negedge clk);
        #1;
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        int t = 0;
        while (log_q.size() < target && t < budget) begin
            step(1);
            t++;
        end
        chk(name, 32'(log_q.size() >= target), 32'd1);
    endtask

    initial begin : stim
        int ev, b0, b1, b2, nf, lat;
        reset = 1'b0; rd_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
        wr0_data = 7'h00; wr1_data = 7'h00; fifo_rxf = 1'b1; fifo_txe = 1'b1;
        fifo_byte = 7'h41;
        step(3);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd1);
        chk("rst_fifo_wr", 32'(fifo_wr), 32'd1);
        chk("rst_bus_z", 32'(fifo_data), 32'h7F);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_acks", 32'({wr0_ack, wr1_ack}), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset = 1'b1;
        step(5);
        chk("idle_flags_inactive", 32'(busy), 32'd0);

        // Back-to-back reads
        wr0_req = 1'b0; wr1_req = 1'b0;
        ev = log_q.size(); b0 = rd_low_cnt; b1 = rd_valid_cnt; nf = rd_fall_q.size();
        rd_req = 1'b1; fifo_rxf = 1'b0;
        wait_events(ev + 2, 60, "rd_two_done");
        rd_req = 1'b0; fifo_rxf = 1'b1;
        step(8);
        chk("rd_low_cycles", rd_low_cnt - b0, 4);
        chk("rd_valid_pulses", rd_valid_cnt - b1, 2);
        chk("rd_data_value", 32'(last_rd_data), 32'h41);
        chk("rd_fall_period", rd_fall_q[nf + 1] - rd_fall_q[nf], 6);

        // Single write from producer 0
        ev = log_q.size(); b0 = ack0_cnt; b1 = wr_low_cnt;
        wr0_data = 7'h0D; wr0_req = 1'b1; fifo_txe = 1'b0;
        wait_events(ev + 1, 40, "wr0_done");
        wr0_req = 1'b0; fifo_txe = 1'b1;
        step(8);
        chk("wr0_ack_pulses", ack0_cnt - b0, 1);
        chk("wr_low_cycles", wr_low_cnt - b1, 2);
        chk("wr_bus_setup", 32'(pre_fall_bus), 32'h0D);
        chk("wr_bus_strobe", 32'(last_wr_bus), 32'h0D);
        chk("wr_bus_hold", 32'(ack_bus), 32'h0D);

        // All three pending from reset
        reset = 1'b0;
        step(2);
        reset = 1'b1;
        ev = log_q.size();
        fifo_byte = 7'h55; wr0_data = 7'h12; wr1_data = 7'h34;
        rd_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1; fifo_rxf = 1'b0; fifo_txe = 1'b0;
        wait_events(ev + 4, 150, "rr_four_done");
        rd_req = 1'b0; wr0_req = 1'b0; wr1_req = 1'b0; fifo_rxf = 1'b1; fifo_txe = 1'b1;
        step(10);
        chk("rr_order_0", log_q[ev], 0);
        chk("rr_order_1", log_q[ev + 1], 1);
        chk("rr_order_2", log_q[ev + 2], 2);
        chk("rr_order_3", log_q[ev + 3], 0);

        // TXE# blocks writes; latency after it drops
        ev = log_q.size(); b0 = wr_low_cnt; b2 = ack1_cnt;
        wr1_data = 7'h2A; wr1_req = 1'b1;
        step(6);
        chk("no_wr_txe_high", wr_low_cnt - b0, 0);
        fifo_txe = 1'b0;
        lat = 0;
        while (fifo_wr !== 1'b0 && lat < 20) begin
            step(1);
            lat++;
        end
        chk("txe_to_wr_latency", lat, 3 + Su);
        wait_events(ev + 1, 40, "wr1_done");
        wr1_req = 1'b0; fifo_txe = 1'b1;
        step(8);
        chk("wr1_ack_pulses", ack1_cnt - b2, 1);

        // Reset during the write strobe
        b0 = ack0_cnt;
        wr0_data = 7'h66; wr0_req = 1'b1; fifo_txe = 1'b0;
        lat = 0;
        while (fifo_wr !== 1'b0 && lat < 30) begin
            step(1);
            lat++;
        end
        chk("wr_strobe_reached", 32'(fifo_wr), 32'd0);
        reset = 1'b0;
        step(1);
        chk("rst_mid_wr_high", 32'(fifo_wr), 32'd1);
        chk("rst_mid_bus_z", 32'(fifo_data), 32'h7F);
        rd_req = 1'b1; fifo_rxf = 1'b0;
        step(1);
        reset = 1'b1;
        ev = log_q.size();
        wait_events(ev + 1, 40, "post_rst_grant");
        chk("post_rst_first_rd", log_q[ev], 0);
        chk("no_ack_aborted", ack0_cnt - b0, 0);
        rd_req = 1'b0; wr0_req = 1'b0; fifo_rxf = 1'b1; fifo_txe = 1'b1;
        step(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
